// File: rtl/mdu_hilo.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU multi-cycle, MTHI/MTLO single-cycle; busy stalls the pipe, starts while busy are dropped.
// Optional MADD/MADDU accumulate is built only when MDU_MADD_EN is defined; otherwise ops 6/7 are no-ops.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [2:0]    op_q;

    logic          is_mul_req;
    logic          is_div_req;
    logic          accept;

    always_comb begin
        is_mul_req = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul_req = is_mul_req || (op == OP_MADD) || (op == OP_MADDU);
`endif
        is_div_req = (op == OP_DIV) || (op == OP_DIVU);
    end

    assign accept = (state == ST_IDLE) && start && (is_mul_req || is_div_req);
    assign busy   = (state == ST_RUN);

    // One shared 64-bit multiplier; signedness chosen by operand extension.
    logic        mul_sgn;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    assign mul_sgn = (op_q == OP_MULT) || (op_q == OP_MADD);
    assign ext_a   = {{32{mul_sgn & a_q[31]}}, a_q};
    assign ext_b   = {{32{mul_sgn & b_q[31]}}, b_q};
    assign prod    = ext_a * ext_b;

    // Signed divide via magnitudes; quotient truncates to zero, remainder follows dividend.
    logic        div_sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    assign div_sgn  = (op_q == OP_DIV);
    assign a_neg    = div_sgn & a_q[31];
    assign b_neg    = div_sgn & b_q[31];
    assign mag_a    = a_neg ? (32'd0 - a_q) : a_q;
    assign mag_b    = b_neg ? (32'd0 - b_q) : b_q;
    assign div_zero = (b_q == 32'd0);
    assign divisor  = div_zero ? 32'd1 : mag_b;
    assign uq       = mag_a / divisor;
    assign ur       = mag_a % divisor;
    assign quo      = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    assign rem      = a_neg ? (32'd0 - ur) : ur;

    logic        res_we;
    logic [63:0] res;

    always_comb begin
        res_we = 1'b0;
        res    = {HI, LO};
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_we = 1'b1;
                res    = prod;
            end
            OP_DIV, OP_DIVU: begin
                res_we = !div_zero;
                res    = {rem, quo};
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                res_we = 1'b1;
                res    = {HI, LO} + prod;
            end
`endif
            default: begin
                res_we = 1'b0;
                res    = {HI, LO};
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= op;
                    cnt   <= is_div_req ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state <= ST_RUN;
                end else if (start && (op == OP_MTHI)) begin
                    HI <= A;
                end else if (start && (op == OP_MTLO)) begin
                    LO <= A;
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    if (res_we) begin
                        {HI, LO} <= res;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected {HI,LO} queued at issue, checked when done pulses.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    mdu_hilo dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        if (reset === 1'b1 && done === 1'b1) begin
            check_val("sb_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_val("commit_hilo", {HI, LO}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        start = 1'b1;
        op    = o;
        A     = v;
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int cycles,
                          input bit disturb);
        int n;
        logic [31:0] lo_before;
        lo_before = LO;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        sb.push_back(exp);
        tick();
        start = 1'b0;
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        check_val({tag, "_done_clr"}, 64'(done), 64'd0);
        n = 0;
        if (disturb) begin
            A     = 32'h7;
            B     = 32'h9;
            start = 1'b1;
            op    = 3'd5;
            tick();
            start = 1'b0;
            n = 1;
            check_val({tag, "_mtlo_ignored"}, 64'(LO), 64'(lo_before));
        end
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_val({tag, "_cycles"}, 64'(n), 64'(cycles));
        check_val({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        #12;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_hilo", {HI, LO}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        mt(3'd4, 32'h11111111);
        check_val("mthi", 64'(HI), 64'h11111111);
        check_val("mthi_nobusy", 64'(busy), 64'd0);
        mt(3'd5, 32'h22222222);
        check_val("mtlo", 64'(LO), 64'h22222222);

        // Abort a divide three cycles in with an asynchronous reset.
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_val("div_mid_busy", 64'(busy), 64'd1);
        check_val("div_mid_hold", {HI, LO}, 64'h11111111_22222222);
        #2 reset = 1'b0;
        #1;
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_hilo", {HI, LO}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check_val("post_rst_idle", 64'(busy), 64'd0);
        mt(3'd4, 32'h12345678);
        check_val("mthi_after_rst", 64'(HI), 64'h12345678);

        run_op("mult",   3'd0, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 5, 1'b0);
        run_op("multu",  3'd1, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5, 1'b0);
        run_op("div",    3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b0);
        run_op("divu",   3'd3, 32'd7, 32'd2, 64'h00000001_00000003, 10, 1'b0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 1'b0);

        tick();
        mt(3'd4, 32'hAAAA0000);
        mt(3'd5, 32'h0000BBBB);
        run_op("div0", 3'd2, 32'd55, 32'd0, 64'hAAAA0000_0000BBBB, 10, 1'b0);

        tick();
        run_op("mult_dist", 3'd0, 32'd3, 32'd5, 64'h00000000_0000000F, 5, 1'b1);
        run_op("multu_b2b", 3'd1, 32'h00010000, 32'h00010000, 64'h00000001_00000000, 5, 1'b0);
        tick();
        check_val("done_pulse_end", 64'(done), 64'd0);

        mt(3'd4, 32'h0);
        mt(3'd5, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", 3'd7, 32'd1, 32'd1, 64'h00000001_00000000, 5, 1'b0);
`else
        start = 1'b1; op = 3'd7; A = 32'd1; B = 32'd1;
        tick();
        start = 1'b0;
        check_val("maddu_nop_busy", 64'(busy), 64'd0);
        check_val("maddu_nop_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
        tick();
        check_val("maddu_nop_done", 64'(done), 64'd0);
`endif

        repeat (2) tick();
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
